// File: rtl/stopwatch_core.sv
// BCD mm:ss stopwatch/timer core: counts up or down on a 1 Hz strobe, with run/pause,
// clear, per-field adjust and terminal-count flags. Minutes are kept as two BCD digits.
module stopwatch_core #(
  parameter int MAX_MIN     = 59,
  parameter bit UP_SATURATE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       adj_tick,
  input  logic       pause_pulse,
  input  logic       clear_pulse,
  input  logic       adj,
  input  logic       sel,
  input  logic       down,
  output logic [3:0] min_ten,
  output logic [3:0] min_unit,
  output logic [2:0] sec_ten,
  output logic [3:0] sec_unit,
  output logic       running,
  output logic       done,
  output logic       wrap
);

  typedef enum logic [1:0] {ST_PAUSED, ST_RUN, ST_ADJ, ST_DONE} state_t;

  localparam logic [3:0] MAX_TEN  = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_UNIT = 4'(MAX_MIN % 10);

  state_t     state_q, state_d;
  logic [3:0] min_ten_q, min_ten_d;
  logic [3:0] min_unit_q, min_unit_d;
  logic [2:0] sec_ten_q, sec_ten_d;
  logic [3:0] sec_unit_q, sec_unit_d;
  logic       wrap_q, wrap_d;

  logic min_at_max, sec_at_59, min_zero, sec_zero;

  assign min_at_max = (min_ten_q == MAX_TEN) && (min_unit_q == MAX_UNIT);
  assign sec_at_59  = (sec_ten_q == 3'd5) && (sec_unit_q == 4'd9);
  assign min_zero   = (min_ten_q == 4'd0) && (min_unit_q == 4'd0);
  assign sec_zero   = (sec_ten_q == 3'd0) && (sec_unit_q == 4'd0);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    min_ten_d  = min_ten_q;
    min_unit_d = min_unit_q;
    sec_ten_d  = sec_ten_q;
    sec_unit_d = sec_unit_q;
    wrap_d     = 1'b0;

    if (clear_pulse) begin
      min_ten_d  = 4'd0;
      min_unit_d = 4'd0;
      sec_ten_d  = 3'd0;
      sec_unit_d = 4'd0;
      state_d    = ST_PAUSED;
    end else begin
      case (state_q)
        ST_PAUSED: begin
          if (adj)              state_d = ST_ADJ;
          else if (pause_pulse) state_d = ST_RUN;
        end

        ST_RUN: begin
          if (adj) begin
            state_d = ST_ADJ;
          end else begin
            if (pause_pulse) state_d = ST_PAUSED;
            if (sec_tick && !down) begin
              if (min_at_max && sec_at_59) begin
                if (UP_SATURATE) begin
                  state_d = ST_DONE;
                end else begin
                  min_ten_d  = 4'd0;
                  min_unit_d = 4'd0;
                  sec_ten_d  = 3'd0;
                  sec_unit_d = 4'd0;
                  wrap_d     = 1'b1;
                end
              end else if (sec_unit_q != 4'd9) begin
                sec_unit_d = sec_unit_q + 4'd1;
              end else begin
                sec_unit_d = 4'd0;
                if (sec_ten_q != 3'd5) begin
                  sec_ten_d = sec_ten_q + 3'd1;
                end else begin
                  sec_ten_d = 3'd0;
                  if (min_unit_q != 4'd9) begin
                    min_unit_d = min_unit_q + 4'd1;
                  end else begin
                    min_unit_d = 4'd0;
                    min_ten_d  = min_ten_q + 4'd1;
                  end
                end
              end
            end else if (sec_tick && down) begin
              // Reaching or sitting at 00:00 ends the countdown; DONE beats a coincident pause.
              if (min_zero && (sec_ten_q == 3'd0) && (sec_unit_q <= 4'd1)) state_d = ST_DONE;
              if (!(min_zero && sec_zero)) begin
                if (sec_unit_q != 4'd0) begin
                  sec_unit_d = sec_unit_q - 4'd1;
                end else begin
                  sec_unit_d = 4'd9;
                  if (sec_ten_q != 3'd0) begin
                    sec_ten_d = sec_ten_q - 3'd1;
                  end else begin
                    sec_ten_d = 3'd5;
                    if (min_unit_q != 4'd0) begin
                      min_unit_d = min_unit_q - 4'd1;
                    end else begin
                      min_unit_d = 4'd9;
                      min_ten_d  = min_ten_q - 4'd1;
                    end
                  end
                end
              end
            end
          end
        end

        ST_ADJ: begin
          if (!adj) begin
            state_d = ST_PAUSED;
          end else if (adj_tick && sel) begin
            if (sec_at_59) begin
              sec_ten_d  = 3'd0;
              sec_unit_d = 4'd0;
            end else if (sec_unit_q != 4'd9) begin
              sec_unit_d = sec_unit_q + 4'd1;
            end else begin
              sec_unit_d = 4'd0;
              sec_ten_d  = sec_ten_q + 3'd1;
            end
          end else if (adj_tick) begin
            if (min_at_max) begin
              min_ten_d  = 4'd0;
              min_unit_d = 4'd0;
            end else if (min_unit_q != 4'd9) begin
              min_unit_d = min_unit_q + 4'd1;
            end else begin
              min_unit_d = 4'd0;
              min_ten_d  = min_ten_q + 4'd1;
            end
          end
        end

        ST_DONE: begin
          if (adj)              state_d = ST_ADJ;
          else if (pause_pulse) state_d = ST_PAUSED;
        end

        default: state_d = ST_PAUSED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PAUSED;
      min_ten_q  <= 4'd0;
      min_unit_q <= 4'd0;
      sec_ten_q  <= 3'd0;
      sec_unit_q <= 4'd0;
      wrap_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
      state_q    <= state_d;
      min_ten_q  <= min_ten_d;
      min_unit_q <= min_unit_d;
      sec_ten_q  <= sec_ten_d;
      sec_unit_q <= sec_unit_d;
      wrap_q     <= wrap_d;
    end
  end

  assign min_ten  = min_ten_q;
  assign min_unit = min_unit_q;
  assign sec_ten  = sec_ten_q;
  assign sec_unit = sec_unit_q;
  assign running  = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: three parameterisations share stimulus and are compared
// against a seconds-count reference model, plus table vectors and directed sequences.
module tb_stopwatch_core;

  logic clk = 1'b0;
  logic rst_n;
  logic sec_tick, adj_tick, pause_pulse, clear_pulse, adj, sel, down;

  logic [3:0] mt[3];
  logic [3:0] mu[3];
  logic [2:0] st[3];
  logic [3:0] su[3];
  logic       running[3];
  logic       done[3];
  logic       wrap[3];

  always #5 clk = ~clk;

  stopwatch_core #(.MAX_MIN(59), .UP_SATURATE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .adj_tick(adj_tick),
    .pause_pulse(pause_pulse), .clear_pulse(clear_pulse), .adj(adj), .sel(sel), .down(down),
    .min_ten(mt[0]), .min_unit(mu[0]), .sec_ten(st[0]), .sec_unit(su[0]),
    .running(running[0]), .done(done[0]), .wrap(wrap[0]));

  stopwatch_core #(.MAX_MIN(59), .UP_SATURATE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .adj_tick(adj_tick),
    .pause_pulse(pause_pulse), .clear_pulse(clear_pulse), .adj(adj), .sel(sel), .down(down),
    .min_ten(mt[1]), .min_unit(mu[1]), .sec_ten(st[1]), .sec_unit(su[1]),
    .running(running[1]), .done(done[1]), .wrap(wrap[1]));

  stopwatch_core #(.MAX_MIN(5), .UP_SATURATE(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .adj_tick(adj_tick),
    .pause_pulse(pause_pulse), .clear_pulse(clear_pulse), .adj(adj), .sel(sel), .down(down),
    .min_ten(mt[2]), .min_unit(mu[2]), .sec_ten(st[2]), .sec_unit(su[2]),
    .running(running[2]), .done(done[2]), .wrap(wrap[2]));

  localparam int MP = 0, MR = 1, MA = 2, MD = 3;

  // Reference state: elapsed time as a plain count of seconds.
  typedef struct {
    int total;
    int st;
    bit wrap;
  } mdl_t;

  typedef struct {
    bit tk, pa, cl, at;
    bit ad, se, dn;
    int total;
    int stt;
    bit w;
  } vec_t;

  mdl_t m[3];
  int   mx[3];
  bit   sat[3];
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t tbl[16];

  function automatic mdl_t mstep(mdl_t c, int mxm, bit s);
    mdl_t r;
    int   top;
    bit   to_done;
    r       = c;
    top     = mxm * 60 + 59;
    to_done = 1'b0;
    r.wrap  = 1'b0;
    if (clear_pulse) begin
      r.total = 0;
      r.st    = MP;
    end else begin
      case (c.st)
        MP: if (adj) r.st = MA; else if (pause_pulse) r.st = MR;
        MR: begin
          if (adj) r.st = MA;
          else begin
            if (sec_tick) begin
              if (!down) begin
                if (c.total == top) begin
                  if (s) to_done = 1'b1;
                  else begin r.total = 0; r.wrap = 1'b1; end
                end else r.total = c.total + 1;
              end else begin
                if (c.total > 0) r.total = c.total - 1;
                if (r.total == 0) to_done = 1'b1;
              end
            end
            if (to_done) r.st = MD;
            else if (pause_pulse) r.st = MP;
          end
        end
        MA: begin
          if (!adj) r.st = MP;
          else if (adj_tick && sel) r.total = (c.total / 60) * 60 + ((c.total % 60) + 1) % 60;
          else if (adj_tick) r.total = (((c.total / 60) + 1) % (mxm + 1)) * 60 + c.total % 60;
        end
        default: if (adj) r.st = MA; else if (pause_pulse) r.st = MP;
      endcase
    end
    return r;
  endfunction

  function automatic logic [17:0] exp_vec(int total, int stt, bit w);
    int mins, secs;
    mins = total / 60;
    secs = total % 60;
    return {4'(mins / 10), 4'(mins % 10), 3'(secs / 10), 4'(secs % 10),
            stt == MR, stt == MD, w};
  endfunction

  function automatic logic [17:0] dut_vec(int i);
    return {mt[i], mu[i], st[i], su[i], running[i], done[i], wrap[i]};
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h  (mt mu st su run done wrap)", name, act, exp);
  endtask

  task automatic expect_i(input string name, input int i, input int total, input int stt, input bit w);
    check(name, dut_vec(i), exp_vec(total, stt, w));
  endtask

  // One clock: model advances at the edge, all three instances compared #1 later.
  task automatic step(input bit tk, input bit pa, input bit cl, input bit at);
    sec_tick = tk; pause_pulse = pa; clear_pulse = cl; adj_tick = at;
    @(posedge clk);
    for (int i = 0; i < 3; i++) m[i] = mstep(m[i], mx[i], sat[i]);
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("model_dut%0d_t%0t", i, $time), dut_vec(i), exp_vec(m[i].total, m[i].st, m[i].wrap));
    sec_tick = 1'b0; pause_pulse = 1'b0; clear_pulse = 1'b0; adj_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic adj_ticks(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    for (int i = 0; i < 3; i++) begin
      m[i] = '{0, MP, 1'b0};
      expect_i($sformatf("reset_dut%0d", i), i, 0, MP, 1'b0);
    end
    #1 rst_n = 1'b1;
  endtask

  initial begin
    mx  = '{59, 59, 5};
    sat = '{1'b0, 1'b1, 1'b0};
    sec_tick = 0; adj_tick = 0; pause_pulse = 0; clear_pulse = 0;
    adj = 0; sel = 0; down = 0;

    //         tk pa cl at  ad se dn  total stt  w
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0,  0, MP, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0,  0, MR, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 0,  1, MR, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 1,  0, MD, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 0, 1,  0, MD, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 0, 1,  0, MP, 0};
    tbl[6]  = '{0, 0, 0, 0, 1, 0, 0,  0, MA, 0};
    tbl[7]  = '{0, 0, 0, 1, 1, 1, 0,  1, MA, 0};
    tbl[8]  = '{0, 0, 0, 1, 1, 0, 0, 61, MA, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 61, MP, 0};
    tbl[10] = '{1, 0, 0, 0, 0, 0, 0, 61, MP, 0};
    tbl[11] = '{0, 1, 0, 0, 0, 0, 1, 61, MR, 0};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 1, 60, MR, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 0, 1, 59, MR, 0};
    tbl[14] = '{1, 1, 0, 0, 0, 0, 0, 60, MP, 0};
    tbl[15] = '{1, 1, 1, 0, 0, 0, 0,  0, MP, 0};

    do_reset();

    for (int k = 0; k < 16; k++) begin
      adj = tbl[k].ad; sel = tbl[k].se; down = tbl[k].dn;
      step(tbl[k].tk, tbl[k].pa, tbl[k].cl, tbl[k].at);
      expect_i($sformatf("tbl%0d", k), 0, tbl[k].total, tbl[k].stt, tbl[k].w);
    end
    adj = 0; sel = 0; down = 0;

    // Count up 61 s from reset.
    do_reset();
    step(0, 1, 0, 0);
    ticks(61);
    expect_i("up_61", 0, 61, MR, 0);

    // Preset max time via adjust, then one tick: wrap / saturate.
    step(0, 0, 1, 0);
    adj = 1; step(0, 0, 0, 0);
    sel = 0; adj_ticks(59);
    sel = 1; adj_ticks(59);
    adj = 0; step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    expect_i("preset_5959", 0, 3599, MR, 0);
    expect_i("preset_0559", 2, 359, MR, 0);
    ticks(1);
    expect_i("wrap_roll", 0, 0, MR, 1);
    expect_i("sat_hold", 1, 3599, MD, 0);
    expect_i("wrap_roll_m5", 2, 0, MR, 1);
    step(0, 0, 0, 0);
    expect_i("wrap_1clk", 0, 0, MR, 0);

    // Countdown from 01:00.
    step(0, 0, 1, 0);
    adj = 1; step(0, 0, 0, 0);
    sel = 0; adj_ticks(1);
    adj = 0; step(0, 0, 0, 0);
    down = 1;
    step(0, 1, 0, 0);
    ticks(60);
    expect_i("down_done", 0, 0, MD, 0);
    ticks(1);
    expect_i("down_done_hold", 0, 0, MD, 0);
    step(0, 1, 0, 0);
    expect_i("done_pause", 0, 0, MP, 0);
    down = 0;

    // Field adjust wraps without carry.
    step(0, 0, 1, 0);
    adj = 1; step(0, 0, 0, 0);
    sel = 1; adj_ticks(58);
    expect_i("adj_0058", 0, 58, MA, 0);
    adj_ticks(3);
    expect_i("adj_sec_wrap", 0, 1, MA, 0);
    sel = 0; adj_ticks(5);
    expect_i("adj_min5", 2, 301, MA, 0);
    adj_ticks(1);
    expect_i("adj_min_wrap", 2, 1, MA, 0);
    expect_i("adj_min6", 0, 361, MA, 0);
    adj = 0; step(0, 0, 0, 0);

    // Same-cycle priority.
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    ticks(9);
    expect_i("run_0009", 0, 9, MR, 0);
    step(1, 1, 1, 0);
    expect_i("clear_wins", 0, 0, MP, 0);
    step(0, 1, 0, 0);
    ticks(9);
    step(1, 1, 0, 0);
    expect_i("tick_then_pause", 0, 10, MP, 0);

    // Async reset mid-count.
    step(0, 0, 1, 0);
    adj = 1; step(0, 0, 0, 0);
    sel = 0; adj_ticks(12);
    sel = 1; adj_ticks(34);
    adj = 0; step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    expect_i("run_1234", 0, 754, MR, 0);
    #2;
    do_reset();
    ticks(1);
    expect_i("tick_after_reset", 0, 0, MP, 0);
    step(0, 1, 0, 0);
    ticks(1);
    expect_i("run_after_reset", 0, 1, MR, 0);

    // Randomised traffic against the model.
    step(0, 0, 1, 0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(31) == 0) adj = ~adj;
      if ($urandom_range(31) == 0) down = ~down;
      sel = 1'($urandom_range(1));
      step($urandom_range(3) == 0, $urandom_range(15) == 0,
           $urandom_range(63) == 0, $urandom_range(3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
